spi_ctrl: RTL and testbench
===========================

# spi_ctrl

SPI controller (mode 0, MSB first) that drives an external SPI peripheral. It is the initiator end of the link our design already exposes as an SPI peripheral. It converts a byte-stream handshake from on-chip logic into sck/csn/sdo waveforms and returns the byte shifted in on sdi for every byte sent. Bytes flagged `tx_last` end the transaction and release csn; other bytes keep csn low so the next byte continues the same transaction.

## Interface
- `TICKS_PER_HALF_BIT`, default 24: clk cycles per sck half-period (H). Legal values are ≥ 2. 48 MHz / (2·24) = 1 MHz sck.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tx_valid`  in  1  byte offered.
- `tx_ready`  out  1  controller accepts; a transfer happens when `tx_valid && tx_ready`.
- `tx_data`  in  8  byte to send, MSB first.
- `tx_last`  in  1  sampled with `tx_data`; 1 = release csn after this byte.
- `rx_valid`  out  1  one-cycle pulse, `rx_data` valid. There is no backpressure.
- `rx_data`  out  8  byte received on sdi; holds its value until the next pulse.
- `spi_sck`  out  1  serial clock; idles low.
- `spi_csn`  out  1  chip select, active-low.
- `spi_sdo`  out  1  controller→peripheral data.
- `spi_sdi`  in  1  peripheral→controller data.

## Operation
- States:
  - IDLE: csn=1, sck=0, sdo=0, tx_ready=1.
  - LEAD: csn=0, sck=0, sdo=bit7.
  - HIGH: sck=1.
  - LOW: sck=0.
  - NEXT: csn=0, sck=0, tx_ready=1.
  - TRAIL: csn=0, sck=0.
  - GAP: csn=1.
- tx_ready=1 only in IDLE and NEXT.
- One half-bit counter is reloaded with H−1 on each state entry. A state lasts H cycles. NEXT waits indefinitely and does not use the counter.
- IDLE + accept → LEAD. The byte is latched, tx_last is latched, and the bit index is set to 7.
- LEAD done → HIGH.
- HIGH, last cycle: shift spi_sdi into the receive register. Sampling at the end of the high phase gives synchronizer-based peripherals the full phase to settle.
- HIGH done:
  - If bit index > 0: → LOW. Decrement the index and drive sdo = next bit.
  - If bit index = 0: pulse rx_valid and load rx_data, then → TRAIL if the latched tx_last=1, else → NEXT.
- LOW done → HIGH.
- NEXT + accept → LEAD with the new byte; csn stays low throughout.
- TRAIL done → GAP (csn rises).
- GAP done → IDLE. This guarantees a minimum csn-high time of H cycles.
- sdo is 0 in IDLE and GAP. In NEXT and TRAIL, sdo holds the last bit sent.
- Offers with tx_ready=0 are ignored. tx_data/tx_last may change freely while busy.
- Reset values: spi_csn=1, spi_sck=0, spi_sdo=0, tx_ready=1 (IDLE), rx_valid=0, rx_data=0x00.
- Reset asserted mid-transfer: all outputs take their reset values immediately (asynchronously). csn rises with no trailing phase. The partial byte is discarded and no rx_valid pulse is produced.

## Timing
- All outputs are registered. Cycle 0 is the accept cycle in IDLE.
- csn falls and sdo=bit7 at cycle 1.
- Bit k (k=0..7, MSB first) has sck high for cycles H+1+2Hk … 2H+2Hk.
- rx_valid pulses at cycle 16H+1, the same cycle sck falls after bit 0.
- Last byte: csn rises at cycle 17H+1 and tx_ready returns at cycle 18H+1.
- Back-to-back bytes with tx_valid held: accepts are 16H+1 cycles apart, and csn never rises between them.
- sck duty is exactly 50% within a byte. The inter-byte low phase is H+1 cycles, or longer when NEXT stalls.

## Structure
- Shared package `spi_pkg`:
  - state encodings (3-bit localparams);
  - SPI mode constant (CPOL=0, CPHA=0).
- Sub-module `spi_ctrl_tick`: down-counter with reload and a `done` output, parameterized by H. This keeps the FSM free of arithmetic.
- The shift registers and FSM stay in `spi_ctrl`.

## Test plan
- Reset: hold rst_n=0, toggle tx_valid → csn=1, sck=0, sdo=0, rx_valid=0, rx_data=0x00, tx_ready=1.
- Single byte, H=2, tx_data=0xA5, tx_last=1, peripheral model returns 0x3C → sdo across the 8 rising edges = 1,0,1,0,0,1,0,1; rx_valid at cycle 33 with rx_data=0x3C; csn rises at cycle 35; tx_ready=1 at cycle 37.
- Burst, H=2: 0x01 (last=0) then 0x80 (last=1), tx_valid held → accepts 33 cycles apart; csn low continuously for 2 bytes; two rx_valid pulses; exactly 16 sck rising edges.
- NEXT stall: 0xFF (last=0), then tx_valid=0 for 20 cycles, then 0x00 (last=1) → csn stays low and sck stays low during the stall; no extra rx_valid pulse; second byte timing matches the LEAD-relative formula.
- Busy ignore: change tx_data and hold tx_valid during a byte → tx_ready=0 throughout HIGH/LOW; transmitted bits equal the latched byte.
- Mid-transfer reset at the 4th rising edge → csn=1 and sck=0 in the same cycle; no rx_valid pulse; the next transaction after reset is bit-exact.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI controller: state encodings, widths and bus mode.
package spi_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_IDX_W = 3;
  localparam int unsigned STATE_W   = 3;

  // SPI mode 0: {CPOL, CPHA} = 2'b00, sck idles low, data sampled on the leading edge phase.
  localparam logic [1:0] SPI_MODE = 2'b00;
  localparam logic       SPI_CPOL = SPI_MODE[1];

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_LEAD  = 3'd1;
  localparam logic [STATE_W-1:0] ST_HIGH  = 3'd2;
  localparam logic [STATE_W-1:0] ST_LOW   = 3'd3;
  localparam logic [STATE_W-1:0] ST_NEXT  = 3'd4;
  localparam logic [STATE_W-1:0] ST_TRAIL = 3'd5;
  localparam logic [STATE_W-1:0] ST_GAP   = 3'd6;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_LEAD  = ST_LEAD,
    S_HIGH  = ST_HIGH,
    S_LOW   = ST_LOW,
    S_NEXT  = ST_NEXT,
    S_TRAIL = ST_TRAIL,
    S_GAP   = ST_GAP
  } state_e;

endpackage

// File: rtl/spi_ctrl_if.sv
// Byte-stream handshake between on-chip logic and the SPI controller.
interface spi_ctrl_if;
  import spi_pkg::*;

  logic              tx_valid;
  logic              tx_ready;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_last;
  logic              rx_valid;
  logic [BYTE_W-1:0] rx_data;

  // Byte producer / response consumer side.
  modport master (
    output tx_valid, tx_data, tx_last,
    input  tx_ready, rx_valid, rx_data
  );

  // Controller side.
  modport slave (
    input  tx_valid, tx_data, tx_last,
    output tx_ready, rx_valid, rx_data
  );

endinterface

// File: rtl/spi_ctrl_tick.sv
// Half-bit timer: reloads to TICKS-1 on request, counts down and flags the last cycle.
module spi_ctrl_tick #(
  parameter int unsigned TICKS = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_done_c
);

  localparam int unsigned CNT_W = $clog2(TICKS);

  logic [CNT_W-1:0] r_cnt;

  // Down-counter; holds at zero until the next reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(TICKS - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/spi_ctrl.sv
// SPI mode-0 initiator: turns a byte handshake into sck/csn/sdo and returns the sdi byte.
module spi_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned TICKS_PER_HALF_BIT = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  spi_ctrl_if.slave  bus,
  output logic       o_spi_sck,
  output logic       o_spi_csn,
  output logic       o_spi_sdo,
  input  logic       i_spi_sdi
);

  state_e               r_state;
  logic [BYTE_W-1:0]    r_tx_sr;
  logic [BYTE_W-1:0]    r_rx_sr;
  logic [BIT_IDX_W-1:0] r_bit_idx;
  logic                 r_last;
  logic [BYTE_W-1:0]    r_rx_data;
  logic                 r_rx_valid;
  logic                 r_sck;
  logic                 r_csn;
  logic                 r_sdo;
  logic                 r_tx_ready;

  state_e               w_state_nxt;
  logic [BYTE_W-1:0]    w_tx_sr_nxt;
  logic [BYTE_W-1:0]    w_rx_sr_nxt;
  logic [BIT_IDX_W-1:0] w_bit_idx_nxt;
  logic                 w_last_nxt;
  logic [BYTE_W-1:0]    w_rx_data_nxt;
  logic                 w_rx_valid_nxt;
  logic                 w_sck_nxt;
  logic                 w_csn_nxt;
  logic                 w_sdo_nxt;
  logic                 w_tx_ready_nxt;

  logic                 w_accept;
  logic                 w_load;
  logic                 w_done;

  assign w_accept = bus.tx_valid && r_tx_ready;
  // Every state entry restarts the half-bit timer.
  assign w_load   = (w_state_nxt != r_state);

  spi_ctrl_tick #(
    .TICKS (TICKS_PER_HALF_BIT)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .o_done_c (w_done)
  );

  // State, shift registers and registered pin/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_bit_idx  <= '0;
      r_last     <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_sck      <= SPI_CPOL;
      r_csn      <= 1'b1;
      r_sdo      <= 1'b0;
      r_tx_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_sr    <= w_tx_sr_nxt;
      r_rx_sr    <= w_rx_sr_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_last     <= w_last_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_sck      <= w_sck_nxt;
      r_csn      <= w_csn_nxt;
      r_sdo      <= w_sdo_nxt;
      r_tx_ready <= w_tx_ready_nxt;
    end
  end

  // Next state and next output values; outputs change only on transitions.
  always_comb begin
    w_state_nxt    = r_state;
    w_tx_sr_nxt    = r_tx_sr;
    w_rx_sr_nxt    = r_rx_sr;
    w_bit_idx_nxt  = r_bit_idx;
    w_last_nxt     = r_last;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_sck_nxt      = r_sck;
    w_csn_nxt      = r_csn;
    w_sdo_nxt      = r_sdo;
    w_tx_ready_nxt = r_tx_ready;

    case (r_state)
      S_IDLE, S_NEXT: begin
        if (w_accept) begin
          w_state_nxt    = S_LEAD;
          w_tx_sr_nxt    = bus.tx_data;
          w_last_nxt     = bus.tx_last;
          w_bit_idx_nxt  = BIT_IDX_W'(BYTE_W - 1);
          w_csn_nxt      = 1'b0;
          w_sck_nxt      = SPI_CPOL;
          w_sdo_nxt      = bus.tx_data[BYTE_W-1];
          w_tx_ready_nxt = 1'b0;
        end
      end
      S_LEAD: begin
        if (w_done) begin
          w_state_nxt = S_HIGH;
          w_sck_nxt   = ~SPI_CPOL;
        end
      end
      S_HIGH: begin
        if (w_done) begin
          // Sample at the end of the high phase so slow peripherals have the whole phase.
          w_rx_sr_nxt = {r_rx_sr[BYTE_W-2:0], i_spi_sdi};
          w_sck_nxt   = SPI_CPOL;
          if (r_bit_idx != '0) begin
            w_state_nxt   = S_LOW;
            w_bit_idx_nxt = r_bit_idx - BIT_IDX_W'(1);
            w_tx_sr_nxt   = {r_tx_sr[BYTE_W-2:0], 1'b0};
            w_sdo_nxt     = r_tx_sr[BYTE_W-2];
          end else begin
            w_rx_valid_nxt = 1'b1;
            w_rx_data_nxt  = {r_rx_sr[BYTE_W-2:0], i_spi_sdi};
            if (r_last) begin
              w_state_nxt = S_TRAIL;
            end else begin
              w_state_nxt    = S_NEXT;
              w_tx_ready_nxt = 1'b1;
            end
          end
        end
      end
      S_LOW: begin
        if (w_done) begin
          w_state_nxt = S_HIGH;
          w_sck_nxt   = ~SPI_CPOL;
        end
      end
      S_TRAIL: begin
        if (w_done) begin
          w_state_nxt = S_GAP;
          w_csn_nxt   = 1'b1;
          w_sdo_nxt   = 1'b0;
        end
      end
      S_GAP: begin
        if (w_done) begin
          w_state_nxt    = S_IDLE;
          w_tx_ready_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_csn_nxt      = 1'b1;
        w_sck_nxt      = SPI_CPOL;
        w_sdo_nxt      = 1'b0;
        w_tx_ready_nxt = 1'b1;
      end
    endcase
  end

  assign bus.tx_ready = r_tx_ready;
  assign bus.rx_valid = r_rx_valid;
  assign bus.rx_data  = r_rx_data;
  assign o_spi_sck    = r_sck;
  assign o_spi_csn    = r_csn;
  assign o_spi_sdo    = r_sdo;

endmodule

// File: tb/tb_spi_ctrl.sv
// Directed bench for spi_ctrl with H=2 and a mode-0 peripheral model on sdi.
module tb_spi_ctrl;
  import spi_pkg::*;

  localparam int unsigned H = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic spi_sck, spi_csn, spi_sdo, spi_sdi;

  spi_ctrl_if bus ();

  spi_ctrl #(
    .TICKS_PER_HALF_BIT (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .o_spi_sck (spi_sck),
    .o_spi_csn (spi_csn),
    .o_spi_sdo (spi_sdo),
    .i_spi_sdi (spi_sdi)
  );

  always #5 clk = ~clk;

  // Peripheral: presents p_val MSB first, shifts out the next bit on each sck fall.
  logic [7:0] p_val;
  logic [7:0] p_sr;
  logic       p_prev_sck;
  always @(spi_csn or spi_sck or p_val) begin
    if (spi_csn !== 1'b0) p_sr = p_val;
    else if (p_prev_sck === 1'b1 && spi_sck === 1'b0) p_sr = {p_sr[6:0], p_sr[7]};
    p_prev_sck = spi_sck;
    spi_sdi    = p_sr[7];
  end

  int n_cmp  = 0;
  int n_fail = 0;

  int          cyc, rises, rx_cnt, rx_cyc, csn_rise, csn_rise_cnt, rdy_rise, acc_n;
  int          acc[4];
  int          rise_cyc[16];
  logic [7:0]  rx_last;
  logic [15:0] sdo_bits;
  logic        prev_sck, prev_csn, prev_rdy;
  int          stall_bad, rdy_hi, guard, a0;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
    end
  endtask

  task automatic clear_obs();
    cyc = 0; rises = 0; rx_cnt = 0; rx_cyc = -1; csn_rise = -1; csn_rise_cnt = 0;
    rdy_rise = -1; acc_n = 0; rx_last = 8'h00; sdo_bits = 16'h0000;
    for (int i = 0; i < 4; i++) acc[i] = -1;
    for (int i = 0; i < 16; i++) rise_cyc[i] = -1;
    prev_sck = spi_sck; prev_csn = spi_csn; prev_rdy = bus.tx_ready;
  endtask

  task automatic sample();
    if (spi_sck === 1'b1 && prev_sck === 1'b0) begin
      if (rises < 16) rise_cyc[rises] = cyc;
      rises++;
      sdo_bits = {sdo_bits[14:0], spi_sdo};
    end
    if (bus.rx_valid === 1'b1) begin
      rx_cnt++;
      rx_cyc  = cyc;
      rx_last = bus.rx_data;
    end
    if (spi_csn === 1'b1 && prev_csn === 1'b0) begin
      csn_rise = cyc;
      csn_rise_cnt++;
    end
    if (bus.tx_ready === 1'b1 && prev_rdy === 1'b0) rdy_rise = cyc;
    if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
      if (acc_n < 4) acc[acc_n] = cyc;
      acc_n++;
    end
    prev_sck = spi_sck; prev_csn = spi_csn; prev_rdy = bus.tx_ready;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      sample();
    end
  endtask

  // Offer a byte in the current cycle, which becomes cycle 0.
  task automatic begin_txn(input logic [7:0] d, input logic l);
    @(negedge clk);
    clear_obs();
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    bus.tx_last  = l;
    sample();
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_last  = 1'b0;
    p_val        = 8'h00;

    // Reset with tx_valid toggling.
    repeat (4) begin
      @(negedge clk);
      bus.tx_valid = ~bus.tx_valid;
    end
    #1;
    check("rst_csn",      32'(spi_csn),       32'd1);
    check("rst_sck",      32'(spi_sck),       32'd0);
    check("rst_sdo",      32'(spi_sdo),       32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid),  32'd0);
    check("rst_rx_data",  32'(bus.rx_data),   32'h00);
    check("rst_tx_ready", 32'(bus.tx_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5, peripheral answers 0x3C.
    p_val = 8'h3C;
    begin_txn(8'hA5, 1'b1);
    step(1);
    bus.tx_valid = 1'b0;
    check("single_csn_c1",   32'(spi_csn),      32'd0);
    check("single_sdo_c1",   32'(spi_sdo),      32'd1);
    check("single_ready_c1", 32'(bus.tx_ready), 32'd0);
    step(39);
    check("single_rises",     32'(rises),          32'd8);
    check("single_sdo_bits",  32'(sdo_bits[7:0]),  32'hA5);
    check("single_first_sck", 32'(rise_cyc[0]),    32'd3);
    check("single_rx_cnt",    32'(rx_cnt),         32'd1);
    check("single_rx_cyc",    32'(rx_cyc),         32'd33);
    check("single_rx_data",   32'(rx_last),        32'h3C);
    check("single_csn_rise",  32'(csn_rise),       32'd35);
    check("single_ready",     32'(rdy_rise),       32'd37);
    check("single_rx_hold",   32'(bus.rx_data),    32'h3C);

    // Burst 0x01 then 0x80 with tx_valid held.
    p_val = 8'h5A;
    begin_txn(8'h01, 1'b0);
    step(1);
    bus.tx_data = 8'h80;
    bus.tx_last = 1'b1;
    step(33);
    bus.tx_valid = 1'b0;
    step(40);
    check("burst_acc_n",     32'(acc_n),        32'd2);
    check("burst_acc1",      32'(acc[1]),       32'd33);
    check("burst_rises",     32'(rises),        32'd16);
    check("burst_sdo_bits",  32'(sdo_bits),     32'h0180);
    check("burst_rx_cnt",    32'(rx_cnt),       32'd2);
    check("burst_rx_cyc",    32'(rx_cyc),       32'd66);
    check("burst_rx_data",   32'(rx_last),      32'h5A);
    check("burst_csn_rises", 32'(csn_rise_cnt), 32'd1);
    check("burst_csn_rise",  32'(csn_rise),     32'd68);

    // NEXT stall: 0xFF, 20 idle cycles, then 0x00 as last byte.
    p_val = 8'hC6;
    begin_txn(8'hFF, 1'b0);
    step(1);
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_last  = 1'b1;
    step(32);
    check("stall_ready_next", 32'(bus.tx_ready), 32'd1);
    check("stall_rx_cnt1",    32'(rx_cnt),       32'd1);
    stall_bad = 0;
    repeat (20) begin
      step(1);
      if (spi_csn !== 1'b0 || spi_sck !== 1'b0 || spi_sdo !== 1'b1 ||
          bus.tx_ready !== 1'b1 || bus.rx_valid !== 1'b0) stall_bad++;
    end
    check("stall_hold", 32'(stall_bad), 32'd0);
    a0 = cyc;
    bus.tx_valid = 1'b1;
    step(1);
    bus.tx_valid = 1'b0;
    step(40);
    check("stall_first_sck", 32'(rise_cyc[8]),  32'(a0 + 3));
    check("stall_rx_cnt",    32'(rx_cnt),       32'd2);
    check("stall_rx_cyc",    32'(rx_cyc),       32'(a0 + 33));
    check("stall_rx_data",   32'(rx_last),      32'hC6);
    check("stall_sdo_bits",  32'(sdo_bits),     32'hFF00);
    check("stall_csn_rises", 32'(csn_rise_cnt), 32'd1);
    check("stall_csn_rise",  32'(csn_rise),     32'(a0 + 35));
    check("stall_ready",     32'(rdy_rise),     32'(a0 + 37));

    // Busy: tx_valid held and tx_data scrambled while a byte is in flight.
    p_val = 8'h81;
    begin_txn(8'hC3, 1'b1);
    rdy_hi = 0;
    for (int c = 1; c <= 35; c++) begin
      step(1);
      if (bus.tx_ready !== 1'b0) rdy_hi++;
      bus.tx_data = 8'($urandom);
      bus.tx_last = 1'($urandom);
    end
    bus.tx_valid = 1'b0;
    step(1);
    if (bus.tx_ready !== 1'b0) rdy_hi++;
    step(4);
    check("busy_ready_low", 32'(rdy_hi),        32'd0);
    check("busy_acc_n",     32'(acc_n),         32'd1);
    check("busy_rises",     32'(rises),         32'd8);
    check("busy_sdo_bits",  32'(sdo_bits[7:0]), 32'hC3);
    check("busy_rx_data",   32'(rx_last),       32'h81);
    check("busy_ready",     32'(rdy_rise),      32'd37);

    // Reset asserted at the 4th sck rise.
    p_val = 8'h77;
    begin_txn(8'h96, 1'b1);
    step(1);
    bus.tx_valid = 1'b0;
    guard = 0;
    while (rises < 4 && guard < 60) begin
      step(1);
      guard++;
    end
    check("mid_rise4_cyc", 32'(cyc), 32'd15);
    rst_n = 1'b0;
    #1;
    check("mid_csn",      32'(spi_csn),      32'd1);
    check("mid_sck",      32'(spi_sck),      32'd0);
    check("mid_sdo",      32'(spi_sdo),      32'd0);
    check("mid_tx_ready", 32'(bus.tx_ready), 32'd1);
    step(3);
    check("mid_rx_cnt",   32'(rx_cnt),       32'd0);
    check("mid_rx_data",  32'(bus.rx_data),  32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    p_val = 8'hA5;
    repeat (2) @(negedge clk);

    // Transaction after reset.
    begin_txn(8'h69, 1'b1);
    step(1);
    bus.tx_valid = 1'b0;
    step(39);
    check("post_rises",    32'(rises),         32'd8);
    check("post_sdo_bits", 32'(sdo_bits[7:0]), 32'h69);
    check("post_rx_cnt",   32'(rx_cnt),        32'd1);
    check("post_rx_cyc",   32'(rx_cyc),        32'd33);
    check("post_rx_data",  32'(rx_last),       32'hA5);
    check("post_csn_rise", 32'(csn_rise),      32'd35);
    check("post_ready",    32'(rdy_rise),      32'd37);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
